calc_sequencer: RTL

Control sequencer for the 8-bit calculator datapath. Turns the raw Enter/Clear buttons and 12 switches into a registered operand/opcode stream for ALU8. Captures ALU8's result and flags into stable registers for the display decoders. Sits between the board I/O and ALU8, replacing ad-hoc state handling in the top level.

---
 rtl/calc_pkg.sv | 27 ++
 rtl/button_edge.sv | 31 +++
 rtl/calc_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer: state encodings,
// default widths, progress-LED patterns and flag bit positions.
package calc_pkg;

  localparam int unsigned DataWDef = 8;
  localparam int unsigned OpWDef   = 4;

  typedef enum logic [2:0] {
    StIdle  = 3'b000,
    StHaveA = 3'b001,
    StHaveB = 3'b010,
    StExec  = 3'b011,
    StShow  = 3'b100
  } state_e;

  localparam logic [5:0] LedIdle  = 6'b000001;
  localparam logic [5:0] LedHaveA = 6'b000011;
  localparam logic [5:0] LedHaveB = 6'b000111;
  localparam logic [5:0] LedExec  = 6'b001111;
  // SHOW places overflow and carry above this fixed low nibble.
  localparam logic [3:0] LedShowLow = 4'b1111;

  localparam int unsigned FlagZero  = 0;
  localparam int unsigned FlagCarry = 1;
  localparam int unsigned FlagOvf   = 2;

endpackage

// File: rtl/button_edge.sv
// Raw button conditioner: two-flop synchronizer, then a registered
// rising-edge pulse one clock wide per press.
module button_edge (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic pulse_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/calc_sequencer.sv
// Operand/opcode sequencer for ALU8 with result/flag capture for display.
// Optional CALC_CHAIN_EN: Enter in SHOW reuses Result as operand A.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned OP_W   = OpWDef
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_W+OP_W-1:0] Switchs,
  input  logic                   Enter,
  input  logic                   Clear,
  output logic [DATA_W-1:0]      AluA,
  output logic [DATA_W-1:0]      AluB,
  output logic [OP_W-1:0]        AluOp,
  input  logic [DATA_W-1:0]      AluResult,
  input  logic                   AluZero,
  input  logic                   AluCarry,
  input  logic                   AluOverflow,
  output logic [DATA_W-1:0]      Result,
  output logic [2:0]             Flags,
  output logic                   ResultValid,
  output logic [2:0]             Phase,
  output logic [5:0]             Leds
);

  logic enter_p;
  logic clear_p;

  button_edge u_enter_edge (
    .clock (clock),
    .reset (reset),
    .btn   (Enter),
    .pulse (enter_p)
  );

  button_edge u_clear_edge (
    .clock (clock),
    .reset (reset),
    .btn   (Clear),
    .pulse (clear_p)
  );

  state_e              state_q;
  logic [DATA_W-1:0]   alu_a_q;
  logic [DATA_W-1:0]   alu_b_q;
  logic [OP_W-1:0]     alu_op_q;
  logic [DATA_W-1:0]   result_q;
  logic [2:0]          flags_q;
  logic                valid_q;
  logic [5:0]          leds_q;

  // Clear outranks Enter; a simultaneous Enter pulse is simply discarded.
  always_ff @(posedge clock) begin
    if (reset || clear_p) begin
      state_q  <= StIdle;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
      leds_q   <= LedIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (enter_p) begin
            alu_a_q <= Switchs[DATA_W-1:0];
            state_q <= StHaveA;
            leds_q  <= LedHaveA;
          end
        end
        StHaveA: begin
          if (enter_p) begin
            alu_b_q <= Switchs[DATA_W-1:0];
            state_q <= StHaveB;
            leds_q  <= LedHaveB;
          end
        end
        StHaveB: begin
          if (enter_p) begin
            alu_op_q <= Switchs[DATA_W+OP_W-1:DATA_W];
            state_q  <= StExec;
            leds_q   <= LedExec;
          end
        end
        StExec: begin
          result_q <= AluResult;
          flags_q  <= {AluOverflow, AluCarry, AluZero};
          valid_q  <= 1'b1;
          state_q  <= StShow;
          leds_q   <= {AluOverflow, AluCarry, LedShowLow};
        end
        StShow: begin
          if (enter_p) begin
            valid_q <= 1'b0;
`ifdef CALC_CHAIN_EN
            alu_a_q <= result_q;
            alu_b_q <= Switchs[DATA_W-1:0];
            state_q <= StHaveB;
            leds_q  <= LedHaveB;
`else
            alu_a_q <= Switchs[DATA_W-1:0];
            state_q <= StHaveA;
            leds_q  <= LedHaveA;
`endif
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          leds_q  <= LedIdle;
        end
      endcase
    end
  end

  assign AluA        = alu_a_q;
  assign AluB        = alu_b_q;
  assign AluOp       = alu_op_q;
  assign Result      = result_q;
  assign Flags       = flags_q;
  assign ResultValid = valid_q;
  assign Phase       = state_q;
  assign Leds        = leds_q;

endmodule
